// File: rtl/axi_line_mem_slave.sv
// Line-granular AXI responder: one full cache line per AR/AW+W transaction, fixed read/write latency.
// Optional define AXI_MEM_STRB_EN turns on per-byte write strobes; default build writes whole lines.
module axi_line_mem_slave #(
  parameter int LINE_BITS   = 512,
  parameter int STRB_BITS   = 64,
  parameter int DEPTH_LINES = 1024,
  parameter int RD_LAT      = 3,
  parameter int WR_LAT      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 axi_awvalid,
  output logic                 axi_awready,
  input  logic [31:0]          axi_awaddr,
  input  logic                 axi_wvalid,
  output logic                 axi_wready,
  input  logic [LINE_BITS-1:0] axi_wdata,
  input  logic [STRB_BITS-1:0] axi_wstrb,
  input  logic                 axi_wlast,
  output logic                 axi_bvalid,
  input  logic                 axi_bready,
  input  logic                 axi_arvalid,
  output logic                 axi_arready,
  input  logic [31:0]          axi_araddr,
  output logic                 axi_rvalid,
  input  logic                 axi_rready,
  output logic [LINE_BITS-1:0] axi_rdata
);
  // state     | meaning
  // W_IDLE    | nothing captured
  // W_COLLECT | one of AW / W captured, waiting for the other
  // W_WAIT    | line committed, counting down to the response
  // W_RESP    | bvalid up until bready
  // R_IDLE    | arready up
  // R_WAIT    | counting down to the line sample
  // R_RESP    | rvalid up until rready
  localparam int IDX_W   = $clog2(DEPTH_LINES);
  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_WAIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

  logic [LINE_BITS-1:0] r_mem [DEPTH_LINES];

  wstate_t              r_wstate, w_wstate_nxt;
  logic                 r_aw_got, r_w_got;
  logic [IDX_W-1:0]     r_aw_idx;
  logic [LINE_BITS-1:0] r_wdata;
  logic [CNT_W-1:0]     r_wcnt;
  logic                 w_aw_hs, w_w_hs, w_commit;
  logic [IDX_W-1:0]     w_widx;
  logic [LINE_BITS-1:0] w_wdata;

  rstate_t              r_rstate, w_rstate_nxt;
  logic [IDX_W-1:0]     r_ridx;
  logic [CNT_W-1:0]     r_rcnt;
  logic [LINE_BITS-1:0] r_rdata;
  logic                 w_ar_hs, w_rsample;

  // Readies come from state only; rst_n gating keeps them low throughout reset.
  assign axi_awready = rst_n && (r_wstate == W_IDLE || r_wstate == W_COLLECT) && !r_aw_got;
  assign axi_wready  = rst_n && (r_wstate == W_IDLE || r_wstate == W_COLLECT) && !r_w_got;
  assign axi_bvalid  = (r_wstate == W_RESP);
  assign axi_arready = rst_n && (r_rstate == R_IDLE);
  assign axi_rvalid  = (r_rstate == R_RESP);
  assign axi_rdata   = r_rdata;

  assign w_aw_hs = axi_awvalid && axi_awready;
  assign w_w_hs  = axi_wvalid && axi_wready;
  assign w_ar_hs = axi_arvalid && axi_arready;
  assign w_widx  = r_aw_got ? r_aw_idx : axi_awaddr[IDX_W+5:6];
  assign w_wdata = r_w_got ? r_wdata : axi_wdata;

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE, W_COLLECT: begin
        if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs)) begin
          w_wstate_nxt = W_WAIT;
          w_commit     = 1'b1;
        end else if (w_aw_hs || w_w_hs) begin
          w_wstate_nxt = W_COLLECT;
        end
      end
      W_WAIT:  if (r_wcnt == '0) w_wstate_nxt = W_RESP;
      W_RESP:  if (axi_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate <= W_IDLE;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_aw_idx <= '0;
      r_wdata  <= '0;
      r_wcnt   <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_commit) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
        r_wcnt   <= CNT_W'(WR_LAT - 1);
      end else begin
        if (w_aw_hs) begin
          r_aw_got <= 1'b1;
          r_aw_idx <= axi_awaddr[IDX_W+5:6];
        end
        if (w_w_hs) begin
          r_w_got <= 1'b1;
          r_wdata <= axi_wdata;
        end
        if (r_wstate == W_WAIT && r_wcnt != '0) r_wcnt <= r_wcnt - 1'b1;
      end
    end
  end

`ifdef AXI_MEM_STRB_EN
  logic [STRB_BITS-1:0] r_wstrb;
  logic [STRB_BITS-1:0] w_wstrb;
  assign w_wstrb = r_w_got ? r_wstrb : axi_wstrb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_wstrb <= '0;
    else if (w_w_hs) r_wstrb <= axi_wstrb;
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < STRB_BITS; b++) begin
        if (w_wstrb[b]) r_mem[w_widx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
  end

  logic w_unused;
  assign w_unused = ^{axi_wlast, axi_awaddr[31:IDX_W+6], axi_awaddr[5:0],
                      axi_araddr[31:IDX_W+6], axi_araddr[5:0]};
`else
  always_ff @(posedge clk) begin
    if (w_commit) r_mem[w_widx] <= w_wdata;
  end

  logic w_unused;
  assign w_unused = ^{axi_wlast, axi_wstrb, axi_awaddr[31:IDX_W+6], axi_awaddr[5:0],
                      axi_araddr[31:IDX_W+6], axi_araddr[5:0]};
`endif

  assign w_rsample = (r_rstate == R_WAIT) && (r_rcnt == '0);

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_WAIT;
      R_WAIT:  if (w_rsample) w_rstate_nxt = R_RESP;
      R_RESP:  if (axi_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Sampling with a nonblocking read returns pre-commit data when the commit shares the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate <= R_IDLE;
      r_ridx   <= '0;
      r_rcnt   <= '0;
      r_rdata  <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_ridx <= axi_araddr[IDX_W+5:6];
        r_rcnt <= CNT_W'(RD_LAT - 1);
      end else if (r_rstate == R_WAIT && r_rcnt != '0) begin
        r_rcnt <= r_rcnt - 1'b1;
      end
      if (w_rsample) r_rdata <= r_mem[r_ridx];
    end
  end
endmodule
